// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and polynomial for the BIST TPG/MISR pair
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // x^8+x^4+x^3+x^2+1; the MISR uses this same constant
  localparam logic [7:0] POLY8        = 8'h1D;
  localparam logic [7:0] DEFAULT_SEED = 8'hFF;

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - Galois LFSR with load and advance enables
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int              NBIT    = 8,
  parameter int              NOUT    = 4,
  parameter logic [NBIT-1:0] RST_VAL = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [NBIT-1:0] i_load_val,
  input  logic            i_adv,
  output logic [NOUT-1:0] o_q
);

  logic [NBIT-1:0] r_q;
  logic [NBIT-1:0] w_next;

  // Galois step: shift left, fold the MSB back through the tap mask
  assign w_next = {r_q[NBIT-2:0], 1'b0} ^ (r_q[NBIT-1] ? POLY8 : '0);
  assign o_q    = r_q[NOUT-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_adv) begin
      r_q <= w_next;
    end
  end

endmodule

// File: rtl/bist_tpg.sv
// rtl/bist_tpg.sv - BIST test pattern generator sequencing INIT/RUN/FLUSH/DONE
module bist_tpg
  import bist_pkg::*;
#(
  parameter int              NBIT  = 8,
  parameter int              NREQ  = 4,
  parameter int              NPAT  = 255,
  parameter int              FLUSH = 2,
  parameter int              CNTW  = 8,
  parameter logic [NBIT-1:0] SEED  = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            shift_en,
  input  logic            scan_in,
  output logic [NREQ-1:0] req,
  output logic            misr_rst,
  output logic            finish,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] pat_cnt,
  output logic            scan_out
);

  localparam logic [CNTW-1:0] LAST  = CNTW'(NPAT - 1);
  localparam int              FW    = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam logic [FW-1:0]   FLAST = FW'((FLUSH > 0) ? FLUSH - 1 : 0);

  state_t          r_state;
  logic [NBIT-1:0] r_seed;
  logic [CNTW-1:0] r_pat_cnt;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_misr_rst;
  logic            r_finish;
  logic            r_busy;
  logic            r_done;

  logic            w_load;
  logic            w_adv;
  logic [NBIT-1:0] w_load_val;

  // All-zero seed would lock the LFSR; substitute the default
  assign w_load_val = (r_seed == '0) ? SEED : r_seed;
  assign w_load     = (r_state == ST_INIT);
  assign w_adv      = (r_state == ST_RUN) && (r_pat_cnt != LAST);

  bist_lfsr #(
    .NBIT    (NBIT),
    .NOUT    (NREQ),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_adv      (w_adv),
    .o_q        (req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_seed      <= SEED;
      r_pat_cnt   <= '0;
      r_flush_cnt <= '0;
      r_misr_rst  <= 1'b0;
      r_finish    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_INIT;
            r_misr_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end else if (shift_en) begin
            r_seed <= {r_seed[NBIT-2:0], scan_in};
          end
        end
        ST_INIT: begin
          r_state    <= ST_RUN;
          r_pat_cnt  <= '0;
          r_misr_rst <= 1'b0;
          r_finish   <= 1'b0;
        end
        ST_RUN: begin
          if (r_pat_cnt == LAST) begin
            r_flush_cnt <= '0;
            if (FLUSH == 0) begin
              r_state  <= ST_DONE;
              r_finish <= 1'b1;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= ST_FLUSH;
            end
          end else begin
            r_pat_cnt <= r_pat_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == FLAST) begin
            r_state  <= ST_DONE;
            r_finish <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign misr_rst = r_misr_rst;
  assign finish   = r_finish;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pat_cnt  = r_pat_cnt;
  assign scan_out = r_seed[NBIT-1];

endmodule

// File: tb/tb_bist_tpg.sv
// tb/tb_bist_tpg.sv - randomized self-checking bench for bist_tpg against a pattern-list model
module tb_bist_tpg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_in = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic shift_a = 1'b0, shift_b = 1'b0;

  logic [3:0] a_req, b_req;
  logic       a_misr, b_misr, a_fin, b_fin, a_busy, b_busy, a_done, b_done, a_so, b_so;
  logic [7:0] a_pc, b_pc;

  always #5 clk = ~clk;

  bist_tpg #(.NPAT(3), .FLUSH(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .shift_en(shift_a), .scan_in(scan_in),
    .req(a_req), .misr_rst(a_misr), .finish(a_fin), .busy(a_busy), .done(a_done),
    .pat_cnt(a_pc), .scan_out(a_so)
  );

  bist_tpg #(.NPAT(1), .FLUSH(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .shift_en(shift_b), .scan_in(scan_in),
    .req(b_req), .misr_rst(b_misr), .finish(b_fin), .busy(b_busy), .done(b_done),
    .pat_cnt(b_pc), .scan_out(b_so)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: seed register, current pattern, counter, done flag
  logic [7:0] m_seed [2];
  logic [7:0] m_pat  [2];
  logic [7:0] m_pc   [2];
  logic       m_done [2];

  logic [3:0] o_req;
  logic       o_misr, o_fin, o_busy, o_done, o_so;
  logic [7:0] o_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next pattern as multiplication by x modulo the field polynomial 0x11D
  function automatic logic [7:0] mul_x(input logic [7:0] v);
    int x;
    x = int'(v) * 2;
    if (x >= 256) x = x ^ 'h11D;
    return x[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int s);
    if (s == 0) begin
      o_req = a_req; o_misr = a_misr; o_fin = a_fin; o_busy = a_busy;
      o_done = a_done; o_so = a_so; o_pc = a_pc;
    end else begin
      o_req = b_req; o_misr = b_misr; o_fin = b_fin; o_busy = b_busy;
      o_done = b_done; o_so = b_so; o_pc = b_pc;
    end
  endtask

  task automatic check_quiet(input int s, input string tag);
    sample(s);
    chk({tag, ".req"},      32'(o_req),  32'(m_pat[s][3:0]));
    chk({tag, ".misr_rst"}, 32'(o_misr), 0);
    chk({tag, ".finish"},   32'(o_fin),  1);
    chk({tag, ".busy"},     32'(o_busy), 0);
    chk({tag, ".done"},     32'(o_done), 32'(m_done[s]));
    chk({tag, ".pat_cnt"},  32'(o_pc),   32'(m_pc[s]));
    chk({tag, ".scan_out"}, 32'(o_so),   32'(m_seed[s][7]));
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_seed[s] = 8'hFF; m_pat[s] = 8'hFF; m_pc[s] = 8'h00; m_done[s] = 1'b0;
    end
  endtask

  // One idle cycle on both instances with optional shifts
  task automatic idle_step(input logic sa, input logic sb, input logic bit_in);
    shift_a = sa; shift_b = sb; scan_in = bit_in;
    tick();
    if (sa) m_seed[0] = {m_seed[0][6:0], bit_in};
    if (sb) m_seed[1] = {m_seed[1][6:0], bit_in};
    shift_a = 1'b0; shift_b = 1'b0;
    check_quiet(0, "idle_a");
    check_quiet(1, "idle_b");
  endtask

  task automatic load_seed(input logic [7:0] seed);
    for (int k = 7; k >= 0; k--) idle_step(1'b1, 1'b1, seed[k]);
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      sample(s);
      chk("rst.req",      32'(o_req),  32'hF);
      chk("rst.finish",   32'(o_fin),  1);
      chk("rst.busy",     32'(o_busy), 0);
      chk("rst.done",     32'(o_done), 0);
      chk("rst.misr_rst", 32'(o_misr), 0);
      chk("rst.pat_cnt",  32'(o_pc),   0);
      chk("rst.scan_out", 32'(o_so),   1);
    end
    tick();
    rst = 1'b0;
    tick();
    check_quiet(0, "post_rst_a");
    check_quiet(1, "post_rst_b");
  endtask

  task automatic drive_noise(input int s, input bit noise);
    logic st, sh;
    st = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    sh = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    scan_in = 1'($urandom_range(0, 1));
    if (s == 0) begin start_a = st; shift_a = sh; end
    else        begin start_b = st; shift_b = sh; end
  endtask

  task automatic clear_drive();
    start_a = 1'b0; start_b = 1'b0; shift_a = 1'b0; shift_b = 1'b0;
  endtask

  task automatic run(input int s, input bit noise, input bit abort_in_flush);
    int npat, nfl;
    npat = (s == 0) ? 3 : 1;
    nfl  = (s == 0) ? 2 : 0;
    // start wins over a same-cycle shift, which must be dropped
    drive_noise(s, noise);
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    clear_drive();
    sample(s);
    chk("init.misr_rst", 32'(o_misr), 1);
    chk("init.finish",   32'(o_fin),  1);
    chk("init.busy",     32'(o_busy), 1);
    chk("init.done",     32'(o_done), 0);
    chk("init.req",      32'(o_req),  32'(m_pat[s][3:0]));
    chk("init.scan_out", 32'(o_so),   32'(m_seed[s][7]));
    m_pat[s] = (m_seed[s] == 8'h00) ? 8'hFF : m_seed[s];
    drive_noise(s, noise);
    for (int i = 0; i < npat; i++) begin
      tick();
      clear_drive();
      sample(s);
      chk("run.req",      32'(o_req),  32'(m_pat[s][3:0]));
      chk("run.pat_cnt",  32'(o_pc),   i);
      chk("run.finish",   32'(o_fin),  0);
      chk("run.busy",     32'(o_busy), 1);
      chk("run.misr_rst", 32'(o_misr), 0);
      chk("run.done",     32'(o_done), 0);
      chk("run.scan_out", 32'(o_so),   32'(m_seed[s][7]));
      if (i < npat - 1) m_pat[s] = mul_x(m_pat[s]);
      drive_noise(s, noise);
    end
    for (int f = 0; f < nfl; f++) begin
      tick();
      clear_drive();
      sample(s);
      chk("flush.req",     32'(o_req),  32'(m_pat[s][3:0]));
      chk("flush.pat_cnt", 32'(o_pc),   npat - 1);
      chk("flush.finish",  32'(o_fin),  0);
      chk("flush.busy",    32'(o_busy), 1);
      chk("flush.done",    32'(o_done), 0);
      if (abort_in_flush) begin
        async_reset_check();
        return;
      end
      drive_noise(s, noise);
    end
    tick();
    clear_drive();
    m_pc[s]   = 8'(npat - 1);
    m_done[s] = 1'b1;
    check_quiet(s, "done");
  endtask

  initial begin
    logic [7:0] rs;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_quiet(0, "reset_a");
    check_quiet(1, "reset_b");
    async_reset_check();

    run(0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0);
    load_seed(8'h01);
    run(0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0);
    load_seed(8'h00);
    run(0, 1'b0, 1'b0);
    idle_step(1'b0, 1'b0, 1'b0);
    run(0, 1'b1, 1'b1);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 4))
        idle_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        rs = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        load_seed(rs);
      end
      run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
